// File: rtl/jk_reg_bank_pkg.sv
// Shared mode encoding for the JK register bank.
package jk_reg_bank_pkg;
  typedef logic [1:0] mode_t;

  localparam mode_t MODE_JK    = 2'b00;
  localparam mode_t MODE_D     = 2'b01;
  localparam mode_t MODE_T     = 2'b10;
  localparam mode_t MODE_COUNT = 2'b11;
endpackage

// File: rtl/jk_reg_bank_cell.sv
// Single-bit JK next-state function; all bank modes reduce to a j/k pair per cell.
module jk_cell (
  input  logic q_i,
  input  logic j_i,
  input  logic k_i,
  output logic q_nxt_o
);
  always_comb begin
    case ({j_i, k_i})
      2'b00:   q_nxt_o = q_i;
      2'b01:   q_nxt_o = 1'b0;
      2'b10:   q_nxt_o = 1'b1;
      default: q_nxt_o = ~q_i;
    endcase
  end
endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of JK cells with JK/D/T/COUNT modes, synchronous active-low reset.
// Optional preset input and PRESET_VAL parameter enabled by JK_REG_BANK_PRESET_EN.
module jk_reg_bank
  import jk_reg_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] MAX_COUNT = '1
`ifdef JK_REG_BANK_PRESET_EN
  , parameter logic [WIDTH-1:0] PRESET_VAL = '1
`endif
) (
  input  logic             clk,
  input  logic             reset,
`ifdef JK_REG_BANK_PRESET_EN
  input  logic             preset,
`endif
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc,
  output logic [WIDTH-1:0] toggled
);
  logic [WIDTH-1:0] q_q, q_d, tgl_q, tgl_d;
  logic [WIDTH-1:0] cell_j, cell_k, cell_q, chain;
  logic             tc_q, tc_d, wrap;

  // Ripple toggle chain: bit i toggles when all lower bits are set.
  assign chain[0] = 1'b1;
  for (genvar i = 1; i < WIDTH; i++) begin : g_chain
    assign chain[i] = chain[i-1] & q_q[i-1];
  end

  // At or beyond the terminal value the counter clears every bit instead.
  assign wrap = (q_q >= MAX_COUNT);

  always_comb begin
    cell_j = j;
    cell_k = k;
    case (mode)
      MODE_D:     cell_k = ~j;
      MODE_T:     cell_k = j;
      MODE_COUNT: begin
        cell_j = wrap ? '0 : chain;
        cell_k = wrap ? '1 : chain;
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .q_i    (q_q[i]),
      .j_i    (cell_j[i]),
      .k_i    (cell_k[i]),
      .q_nxt_o(cell_q[i])
    );
  end

  always_comb begin
    q_d   = q_q;
    tc_d  = 1'b0;
    tgl_d = '0;
`ifdef JK_REG_BANK_PRESET_EN
    if (preset) begin
      q_d   = PRESET_VAL;
      tgl_d = PRESET_VAL ^ q_q;
    end else
`endif
    if (en) begin
      q_d   = cell_q;
      tgl_d = cell_q ^ q_q;
      tc_d  = (mode == MODE_COUNT) && (cell_q == MAX_COUNT);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q   <= RESET_VAL;
      tc_q  <= 1'b0;
      tgl_q <= '0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      tgl_q <= tgl_d;
    end
  end

  assign q       = q_q;
  assign qn      = ~q_q;
  assign tc      = tc_q;
  assign toggled = tgl_q;
endmodule

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench for jk_reg_bank (WIDTH=8, RESET_VAL=5A, MAX_COUNT=9).
module tb_jk_reg_bank;
  localparam logic [7:0] RV   = 8'h5A;
  localparam logic [7:0] MAXC = 8'd9;
  localparam logic [7:0] PV   = 8'hFF;
`ifdef JK_REG_BANK_PRESET_EN
  localparam bit PRE_ON = 1'b1;
`else
  localparam bit PRE_ON = 1'b0;
`endif

  localparam logic [1:0] M_JK = 2'b00, M_D = 2'b01, M_T = 2'b10, M_CNT = 2'b11;

  logic       clk = 1'b0;
  logic       reset, en, preset;
  logic [1:0] mode;
  logic [7:0] j, k, q, qn, toggled;
  logic       tc;

  typedef struct {
    logic [7:0] q;
    logic       tc;
    logic [7:0] tg;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic [7:0] mq;
  logic [7:0] exp_qn;
  int checks = 0;
  int fails  = 0;

  jk_reg_bank #(
    .WIDTH    (8),
    .RESET_VAL(RV),
    .MAX_COUNT(MAXC)
`ifdef JK_REG_BANK_PRESET_EN
    , .PRESET_VAL(PV)
`endif
  ) dut (
    .clk    (clk),
    .reset  (reset),
`ifdef JK_REG_BANK_PRESET_EN
    .preset (preset),
`endif
    .en     (en),
    .mode   (mode),
    .j      (j),
    .k      (k),
    .q      (q),
    .qn     (qn),
    .tc     (tc),
    .toggled(toggled)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, expv, $time);
    end
  endtask

  // Drive one cycle and push the model's view of the state after the next edge.
  task automatic drive(input logic r, input logic e, input logic [1:0] m,
                       input logic [7:0] jj, input logic [7:0] kk, input logic p);
    exp_t x;
    logic [7:0] nq;
    @(negedge clk);
    reset = r; en = e; mode = m; j = jj; k = kk; preset = p;
    x.tc = 1'b0;
    x.tg = '0;
    if (!r) begin
      nq = RV;
    end else if (PRE_ON && p) begin
      nq   = PV;
      x.tg = nq ^ mq;
    end else if (!e) begin
      nq = mq;
    end else begin
      case (m)
        M_JK:    nq = (jj & ~mq) | (~kk & mq);
        M_D:     nq = jj;
        M_T:     nq = mq ^ jj;
        default: nq = (mq >= MAXC) ? 8'd0 : mq + 8'd1;
      endcase
      x.tc = (m == M_CNT) && (nq == MAXC);
      x.tg = nq ^ mq;
    end
    x.q = nq;
    sb.push_back(x);
    mq = nq;
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      cur    = sb.pop_front();
      exp_qn = ~cur.q;
      chk("q", 32'(q), 32'(cur.q));
      chk("qn", 32'(qn), 32'(exp_qn));
      chk("tc", 32'(tc), 32'(cur.tc));
      chk("toggled", 32'(toggled), 32'(cur.tg));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; en = 1'b0; preset = 1'b0; mode = M_JK; j = '0; k = '0;
    mq = 'x;

    // Reset overrides en and mode
    drive(0, 1, M_CNT, 8'hFF, 8'hFF, 0);
    drive(0, 1, M_CNT, 8'hFF, 8'hFF, 0);

    drive(1, 1, M_JK, 8'hF0, 8'h0F, 0);
    drive(1, 1, M_JK, 8'hFF, 8'hFF, 0);
    drive(1, 1, M_JK, 8'h00, 8'h00, 0);

    drive(1, 1, M_D, 8'h3C, 8'h00, 0);
    drive(1, 1, M_T, 8'h81, 8'h00, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 2'($urandom), 8'($urandom), 8'($urandom), 0);

    // Count 1..9 then wrap
    drive(1, 1, M_D, 8'h00, 8'h00, 0);
    for (int i = 0; i < 10; i++) drive(1, 1, M_CNT, 8'($urandom), 8'($urandom), 0);

    // Abort mid-count
    for (int i = 0; i < 6; i++) drive(1, 1, M_CNT, 8'h00, 8'h00, 0);
    drive(0, 1, M_CNT, 8'h00, 8'h00, 0);
    drive(1, 1, M_CNT, 8'h00, 8'h00, 0);

    // Out-of-range entry into COUNT wraps to 0
    drive(1, 1, M_D, 8'hBD, 8'h00, 0);
    drive(1, 1, M_CNT, 8'h00, 8'h00, 0);

    if (PRE_ON) begin
      drive(1, 1, M_JK, 8'h00, 8'hFF, 1);
      drive(0, 1, M_JK, 8'h00, 8'h00, 1);
      drive(1, 0, M_JK, 8'h00, 8'h00, 1);
    end

    for (int i = 0; i < 60; i++)
      drive(($urandom % 12) != 0, ($urandom % 4) != 0, 2'($urandom),
            8'($urandom), 8'($urandom), PRE_ON && (($urandom % 8) == 0));

    drive(1, 0, M_JK, 8'h00, 8'h00, 0);
    repeat (3) @(negedge clk);
    chk("drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
